// File: rtl/alu_pkg.sv
// Shared definitions for the ALU add stage: operation encoding, flag bit
// positions and the buffer state encoding.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    // Operation codes presented by decode.
    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_SLT  = 2'd2,
        ALU_SLTU = 2'd3
    } alu_op_e;

    // Bit positions inside out_flags = {Z,N,C,V}.
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_W = 4;

    // Output buffer occupancy; ST_SKID is only reachable in the skid build.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/alu_add_stage_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups whose group
// generate/propagate terms chain the carry between groups.
module LookAheadCarryAdder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    // Per-bit generate and propagate terms.
    always_comb begin
        g = a & b;
        p = a ^ b;
    end

    // Carries within each group expanded from the group carry-in; group
    // carry-out uses the group generate/propagate terms.
    always_comb begin
        c = '0;
        c[0] = cin;
        for (int unsigned grp = 0; grp < 8; grp++) begin
            int unsigned bs;
            bs = grp * 4;
            c[bs+1] = g[bs] | (p[bs] & c[bs]);
            c[bs+2] = g[bs+1] | (p[bs+1] & g[bs]) | (p[bs+1] & p[bs] & c[bs]);
            c[bs+3] = g[bs+2] | (p[bs+2] & g[bs+1]) | (p[bs+2] & p[bs+1] & g[bs])
                    | (p[bs+2] & p[bs+1] & p[bs] & c[bs]);
            c[bs+4] = (g[bs+3] | (p[bs+3] & g[bs+2]) | (p[bs+3] & p[bs+2] & g[bs+1])
                    | (p[bs+3] & p[bs+2] & p[bs+1] & g[bs]))
                    | (p[bs+3] & p[bs+2] & p[bs+1] & p[bs] & c[bs]);
        end
    end

    // Sum bits and final carry-out.
    always_comb begin
        sum  = p ^ c[31:0];
        cout = c[32];
    end

endmodule

// File: rtl/alu_add_stage.sv
// ALU add/sub/compare stage with a valid/ready handshake on both sides and
// one cycle of latency. Define ALU_ADD_STAGE_SKID_EN for a two-entry skid
// buffer with a registered in_ready; otherwise a single output register with
// combinational in_ready is built.
module alu_add_stage
    import alu_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags
);

    localparam int unsigned ENT_W = XLEN + FLAG_W + TAG_W;

    alu_op_e           op;
    logic              sub_mode;
    logic [XLEN-1:0]   b_eff;
    logic [XLEN-1:0]   sum;
    logic              cout;
    logic [FLAG_W-1:0] flags;
    logic [XLEN-1:0]   result;
    logic [ENT_W-1:0]  new_ent;
    logic [ENT_W-1:0]  out_q;
    buf_state_e        state_q, state_d;
    logic              accept;
    logic              load_out;

    assign op = alu_op_e'(in_op);

    // Every op except ADD subtracts: invert b and carry in a one.
    always_comb begin
        sub_mode = (op != ALU_ADD);
        b_eff    = sub_mode ? ~in_b : in_b;
    end

    LookAheadCarryAdder32 u_adder (
        .a    (in_a),
        .b    (b_eff),
        .cin  (sub_mode),
        .sum  (sum),
        .cout (cout)
    );

    // Flags always describe the raw sum; compares derive their bit from them.
    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (sum == '0);
        flags[FLAG_N] = sum[XLEN-1];
        flags[FLAG_C] = cout;
        flags[FLAG_V] = (in_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != in_a[XLEN-1]);
        case (op)
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, flags[FLAG_N] ^ flags[FLAG_V]};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, ~flags[FLAG_C]};
            default:  result = sum;
        endcase
        new_ent = {result, flags, in_tag};
    end

    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q != ST_EMPTY);

`ifdef ALU_ADD_STAGE_SKID_EN

    logic [ENT_W-1:0] skid_q;
    logic             in_ready_q;
    logic             load_skid;
    logic             from_skid;

    assign in_ready = in_ready_q;

    // Occupancy transitions; a second entry parks in the skid register and
    // moves to the output once downstream drains.
    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_FULL;
                    load_out = 1'b1;
                end
            end
            ST_FULL: begin
                if (accept && out_ready) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = ST_SKID;
                    load_skid = 1'b1;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_ready) begin
                    state_d   = ST_FULL;
                    load_out  = 1'b1;
                    from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State, data registers and the registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_SKID);
            if (load_out)
                out_q <= from_skid ? skid_q : new_ent;
            if (load_skid)
                skid_q <= new_ent;
        end
    end

`else

    assign in_ready = !out_valid || out_ready;

    // Single register: refill on accept, empty on drain without refill.
    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_FULL;
                    load_out = 1'b1;
                end
            end
            ST_FULL: begin
                if (accept)
                    load_out = 1'b1;
                else if (out_ready)
                    state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State and output data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_out)
                out_q <= new_ent;
        end
    end

`endif

    assign out_result = out_q[ENT_W-1 -: XLEN];
    assign out_flags  = out_q[TAG_W +: FLAG_W];
    assign out_tag    = out_q[TAG_W-1:0];

endmodule

// File: tb/tb_alu_add_stage.sv
// Self-checking bench for alu_add_stage: directed vectors, throughput,
// stall, reset-during-stall and randomized traffic against a reference
// queue. Honours ALU_ADD_STAGE_SKID_EN for the buffering-dependent checks.
module tb_alu_add_stage;
    import alu_pkg::*;

    localparam int unsigned TAG_W = 5;
`ifdef ALU_ADD_STAGE_SKID_EN
    localparam int STALL_CAP = 2;
`else
    localparam int STALL_CAP = 1;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;

    alu_add_stage #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      res;
        logic [3:0]       fl;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   accepts = 0;
    int   drains = 0;

    logic             obs_valid;
    logic             obs_ready;
    logic [31:0]      obs_result;
    logic [3:0]       obs_flags;
    logic [TAG_W-1:0] obs_tag;

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Textbook reference: unsigned/signed compares and overflow rules.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [TAG_W-1:0] tag);
        exp_t e;
        logic [32:0] wide;
        logic [31:0] s;
        logic        c, v;
        if (op == 2'd0) begin
            wide = {1'b0, a} + {1'b0, b};
            s = wide[31:0];
            c = wide[32];
            v = (a[31] == b[31]) && (s[31] != a[31]);
        end else begin
            s = a - b;
            c = (a >= b);
            v = (a[31] != b[31]) && (s[31] != a[31]);
        end
        case (op)
            2'd2:    e.res = {31'd0, ($signed(a) < $signed(b))};
            2'd3:    e.res = {31'd0, (a < b)};
            default: e.res = s;
        endcase
        e.fl  = {(s == 32'd0), s[31], c, v};
        e.tag = tag;
        return e;
    endfunction

    // One clock: drive at posedge+1, observe and score at negedge.
    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag, input logic rdy);
        logic acc, drn;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = rdy;
        @(negedge clk);
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        check_val("out_valid", {63'd0, out_valid}, {63'd0, (q.size() != 0)});
        if (q.size() != 0) begin
            check_val("out_result", {32'd0, out_result}, {32'd0, q[0].res});
            check_val("out_flags", {60'd0, out_flags}, {60'd0, q[0].fl});
            check_val("out_tag", 64'(out_tag), 64'(q[0].tag));
        end
`ifdef ALU_ADD_STAGE_SKID_EN
        check_val("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
`else
        check_val("in_ready", {63'd0, in_ready}, {63'd0, (q.size() == 0) || rdy});
`endif
        obs_valid  = out_valid;
        obs_ready  = in_ready;
        obs_result = out_result;
        obs_flags  = out_flags;
        obs_tag    = out_tag;
        if (drn && q.size() != 0) begin
            void'(q.pop_front());
            drains++;
        end
        if (acc) begin
            q.push_back(model(op, a, b, tag));
            accepts++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner[5];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0)
            return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int acc0, drn0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_op = 2'd0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        out_ready = 1'b0;

        // Reset values
        #3;
        check_val("rst_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_result", {32'd0, out_result}, 64'd0);
        check_val("rst_flags", {60'd0, out_flags}, 64'd0);
        check_val("rst_tag", 64'(out_tag), 64'd0);
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed vectors with hand-computed results
        step(1'b1, ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3, 1'b1);
        step(1'b1, ALU_SUB, 32'h8000_0000, 32'h0000_0001, 5'd4, 1'b1);
        check_val("add_valid", {63'd0, obs_valid}, 64'd1);
        check_val("add_result", {32'd0, obs_result}, 64'h0);
        check_val("add_flags", {60'd0, obs_flags}, 64'b1010);
        check_val("add_tag", 64'(obs_tag), 64'd3);
        step(1'b1, ALU_SLT, 32'h8000_0000, 32'h0000_0001, 5'd5, 1'b1);
        check_val("sub_result", {32'd0, obs_result}, 64'h7FFF_FFFF);
        check_val("sub_flags", {60'd0, obs_flags}, 64'b0011);
        step(1'b1, ALU_SLTU, 32'h0000_0001, 32'h0000_0002, 5'd6, 1'b1);
        check_val("slt_result", {32'd0, obs_result}, 64'h1);
        check_val("slt_flags", {60'd0, obs_flags}, 64'b0011);
        step(1'b1, ALU_SLTU, 32'h0000_0002, 32'h0000_0001, 5'd7, 1'b1);
        check_val("sltu_lt_result", {32'd0, obs_result}, 64'h1);
        check_val("sltu_lt_flags", {60'd0, obs_flags}, 64'b0100);
        step(1'b0, ALU_ADD, '0, '0, '0, 1'b1);
        check_val("sltu_ge_result", {32'd0, obs_result}, 64'h0);
        check_val("sltu_ge_flags", {60'd0, obs_flags}, 64'b0010);
        step(1'b0, ALU_ADD, '0, '0, '0, 1'b1);

        // Back-to-back throughput: one accept and one drain every cycle
        acc0 = accepts;
        drn0 = drains;
        for (int i = 0; i < 100; i++)
            step(1'b1, 2'(i % 4), 32'(i * 32'h0101_0101), 32'(32'hFFFF_0000 - i), 5'(i), 1'b1);
        step(1'b0, ALU_ADD, '0, '0, '0, 1'b1);
        check_val("tput_accepts", 64'(accepts - acc0), 64'd100);
        check_val("tput_drains", 64'(drains - drn0), 64'd100);

        // Stall: downstream blocked for 5 cycles with upstream always valid
        acc0 = accepts;
        drn0 = drains;
        for (int i = 0; i < 5; i++)
            step(1'b1, ALU_SUB, 32'(100 + i), 32'(i), 5'(20 + i), 1'b0);
        check_val("stall_accepts", 64'(accepts - acc0), 64'(STALL_CAP));
        check_val("stall_in_ready", {63'd0, obs_ready}, 64'd0);
        for (int i = 0; i < 10 && q.size() != 0; i++)
            step(1'b0, ALU_ADD, '0, '0, '0, 1'b1);
        check_val("stall_drained", 64'(drains - drn0), 64'(STALL_CAP));
        check_val("stall_queue_empty", 64'(q.size()), 64'd0);

        // Reset while an entry is stalled
        step(1'b1, ALU_ADD, 32'h11, 32'h22, 5'd9, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_valid", {63'd0, out_valid}, 64'd0);
        check_val("midrst_result", {32'd0, out_result}, 64'd0);
        check_val("midrst_flags", {60'd0, out_flags}, 64'd0);
        check_val("midrst_tag", 64'(out_tag), 64'd0);
        check_val("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            step(1'b0, ALU_ADD, '0, '0, '0, 1'b1);
        check_val("midrst_no_stale", {63'd0, obs_valid}, 64'd0);

        // Randomized traffic against the reference queue
        for (int i = 0; i < 20000; i++)
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 pick_operand(), pick_operand(), 5'($urandom), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 10 && q.size() != 0; i++)
            step(1'b0, ALU_ADD, '0, '0, '0, 1'b1);
        check_val("final_queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
